// File: rtl/axi_lite_regs_v2.sv
// AXI4-Lite register slave: RW, WO and RO banks with write/read pulses and
// decode-error responses. Separate write and read FSMs run concurrently.
module axi_lite_regs_v2 #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter bit          C_USE_WSTRB        = 0,
    parameter logic [31:0] C_BAR0_BASEADDR    = 32'hFFFF_FFFF,
    parameter logic [31:0] C_BAR0_HIGHADDR    = 32'h0000_0000,
    parameter int          NUM_RW_REGS        = 1,
    parameter int          NUM_WO_REGS        = 1,
    parameter int          NUM_RO_REGS        = 1
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [NUM_RW_REGS*32-1:0]         rw_regs,
    input  logic [NUM_RW_REGS*32-1:0]         rw_defaults,
    output logic [NUM_WO_REGS*32-1:0]         wo_regs,
    input  logic [NUM_WO_REGS*32-1:0]         wo_defaults,
    output logic [NUM_WO_REGS-1:0]            wo_wr_pulse,
    input  logic [NUM_RO_REGS*32-1:0]         ro_regs,
    output logic [NUM_RO_REGS-1:0]            ro_rd_pulse
);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NUM_REGS = NUM_RW_REGS + NUM_WO_REGS + NUM_RO_REGS;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    logic [NUM_RW_REGS-1:0][31:0] rw_q;
    logic [NUM_WO_REGS-1:0][31:0] wo_q;
    assign rw_regs = rw_q;
    assign wo_regs = wo_q;

    logic [AW-1:0]   aw_addr_q;
    logic [DW-1:0]   w_data_q;
    logic [DW/8-1:0] w_strb_q, strb_eff;
    logic            aw_done, w_done;
    logic            aw_hs, w_hs, ar_hs;

    assign aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_hs     = s_axi_wvalid && s_axi_wready;
    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign strb_eff = C_USE_WSTRB ? w_strb_q : '1;

    // Write-side decode works on the captured address during W_EXEC.
    logic [AW-1:0] w_idx;
    logic [1:0]    w_resp;
    always_comb begin
        w_idx  = (aw_addr_q - AW'(C_BAR0_BASEADDR)) >> 2;
        w_resp = OKAY;
        if (aw_addr_q < AW'(C_BAR0_BASEADDR) || aw_addr_q > AW'(C_BAR0_HIGHADDR))
            w_resp = DECERR;
        else if (w_idx >= AW'(NUM_RW_REGS + NUM_WO_REGS))
            w_resp = SLVERR;
    end

    // Read-side decode works on the live address, sampled at acceptance.
    logic [AW-1:0]          r_idx;
    logic [1:0]             r_resp;
    logic [DW-1:0]          r_data;
    logic [NUM_RO_REGS-1:0] r_ro_hit;
    always_comb begin
        r_idx    = (s_axi_araddr - AW'(C_BAR0_BASEADDR)) >> 2;
        r_resp   = OKAY;
        r_data   = '0;
        r_ro_hit = '0;
        if (s_axi_araddr < AW'(C_BAR0_BASEADDR) || s_axi_araddr > AW'(C_BAR0_HIGHADDR))
            r_resp = DECERR;
        else if (r_idx >= AW'(NUM_REGS))
            r_resp = SLVERR;
        else begin
            for (int i = 0; i < NUM_RW_REGS; i++)
                if (r_idx == AW'(i)) r_data = rw_q[i];
            for (int i = 0; i < NUM_RO_REGS; i++)
                if (r_idx == AW'(NUM_RW_REGS + NUM_WO_REGS + i)) begin
                    r_data      = ro_regs[32*i +: 32];
                    r_ro_hit[i] = 1'b1;
                end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            rw_q          <= rw_defaults;
            wo_q          <= wo_defaults;
            wo_wr_pulse   <= '0;
        end else begin
            wo_wr_pulse <= '0;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) aw_addr_q <= s_axi_awaddr;
                    if (w_hs) begin
                        w_data_q <= s_axi_wdata;
                        w_strb_q <= s_axi_wstrb;
                    end
                    aw_done       <= aw_done || aw_hs;
                    w_done        <= w_done || w_hs;
                    s_axi_awready <= !(aw_done || aw_hs);
                    s_axi_wready  <= !(w_done || w_hs);
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        wstate        <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    if (w_resp == OKAY) begin
                        for (int i = 0; i < NUM_RW_REGS; i++)
                            if (w_idx == AW'(i))
                                for (int b = 0; b < 4; b++)
                                    if (strb_eff[b]) rw_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                        for (int i = 0; i < NUM_WO_REGS; i++)
                            if (w_idx == AW'(NUM_RW_REGS + i)) begin
                                wo_wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < 4; b++)
                                    if (strb_eff[b]) wo_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                            end
                    end
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= w_resp;
                    wstate       <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= OKAY;
            s_axi_rdata   <= '0;
            ro_rd_pulse   <= '0;
        end else begin
            ro_rd_pulse <= '0;
            case (rstate)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= r_data;
                        s_axi_rresp   <= r_resp;
                        ro_rd_pulse   <= r_ro_hit;
                        rstate        <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
